matrix_op_sequencer: RTL and testbench
======================================

MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

Interface
REQ-001 Parameter DATA_W, default 256; width of the shared matrix databus and of the operand and result words (4x4 of 16-bit).
REQ-002 Parameter UNITS, default 4, legal range 1-4; number of attached matrix units (transpose, add, ...).
REQ-003 Parameter TIMEOUT_CYCLES, default 16; READ-phase watchdog limit (used only with MATSEQ_TIMEOUT_EN).
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset_l  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  sequencer accepts a command.
REQ-008 cmd_unit  in  2  target unit index.
REQ-009 cmd_operand  in  DATA_W  matrix operand to load into the target unit.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed.
REQ-012 rsp_data  out  DATA_W  result matrix.
REQ-013 rsp_status  out  2  00 ok, 01 bad unit, 10 timeout.
REQ-014 bus_out  out  DATA_W  value the sequencer drives onto the databus.
REQ-015 bus_oe  out  1  databus output enable (top level builds the tristate).
REQ-016 bus_in  in  DATA_W  databus as sampled.
REQ-017 unit_sel  out  UNITS  one-hot unit select.
REQ-018 unit_rw  out  1  1 = unit loads from the bus, 0 = unit drives its result.
REQ-019 unit_en  out  1  unit enable.
REQ-020 unit_done  in  1  done from the selected unit, treated as asserted only when logic 1 (z/x = not done).
REQ-021 busy  out  1  high in every state except IDLE.
REQ-022 op_count  out  16  count of status-ok completions.

Function
REQ-023 The FSM SHALL have the states IDLE, WRITE, READ and RESP, and SHALL contain no other state.
REQ-024 IDLE: cmd_ready=1; on cmd_valid with cmd_ready high, latch cmd_unit and cmd_operand; go to WRITE, or go to RESP with status 01 and rsp_data=0 when cmd_unit >= UNITS.
REQ-025 WRITE (exactly 1 cycle): bus_oe=1, bus_out=latched operand, unit_sel=onehot(unit), unit_rw=1, unit_en=1; the next state is READ.
REQ-026 READ: bus_oe=0, unit_sel held, unit_rw=0, unit_en=1; at the first rising edge where unit_done=1, capture bus_in into rsp_data, set status 00 and go to RESP.
REQ-027 RESP: rsp_valid=1, with rsp_data and rsp_status stable until the handshake; when rsp_ready=1, return to IDLE on the next edge.
REQ-028 unit_done asserted during IDLE, WRITE or RESP SHALL be ignored.
REQ-029 Outside WRITE and READ, unit_sel, unit_en, unit_rw and bus_oe SHALL be 0 and bus_out SHALL be 0.
REQ-030 Minimum latency SHALL be 3 cycles from the command handshake to rsp_valid, when done is seen in the first READ cycle.
REQ-031 cmd_ready SHALL be low outside IDLE, so there is only one command in flight and no back-to-back overlap.
REQ-032 op_count SHALL increment by 1 on each RESP handshake with status 00 and wrap from 0xFFFF to 0.
REQ-033 rsp_ready held high while entering RESP SHALL allow exactly one RESP cycle.

Reset
REQ-034 While reset_l=0, asynchronously and regardless of state: state=IDLE; rsp_valid, rsp_data, rsp_status, bus_oe, bus_out, unit_sel, unit_rw, unit_en, busy and op_count SHALL all be 0, and cmd_ready=0 while reset_l is low.
REQ-035 A reset in the middle of an operation SHALL discard the in-flight command with no response, and bus_oe SHALL drop immediately.
REQ-036 cmd_ready SHALL be 1 on the first rising edge after reset_l deasserts.

Configuration
REQ-037 With MATSEQ_TIMEOUT_EN defined, a counter SHALL be cleared on entry to READ; if TIMEOUT_CYCLES READ cycles elapse without unit_done, go to RESP with status 10 and rsp_data=0.
REQ-038 With MATSEQ_TIMEOUT_EN undefined, READ SHALL wait indefinitely, and status 10 SHALL never occur.

Verification
REQ-039 Transpose: unit 0, operand rows 1..16 (row 3 first) with done 1 cycle into READ -> rsp_valid 3 cycles after the handshake, rsp_data = transposed matrix, status 00, op_count=1.
REQ-040 Bad unit: UNITS=2, cmd_unit=3 -> WRITE skipped, unit_sel never nonzero, RESP status 01, data 0, op_count unchanged.
REQ-041 Backpressure: rsp_ready low for 5 cycles -> rsp_valid, rsp_data and status held; cmd_ready stays 0 until 1 cycle after the handshake.
REQ-042 Mid-op reset: reset_l pulsed low during READ -> bus_oe and unit_sel go to 0 immediately, no rsp_valid, cmd_ready=1 after release.
REQ-043 Timeout (MATSEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): unit_done held at z -> status 10 after 16 READ cycles; without the macro, no response after 100 cycles.
REQ-044 Spurious done: unit_done=1 during WRITE and IDLE -> ignored; the FSM still waits in READ for a fresh done.

Source files
------------

// File: rtl/matrix_op_sequencer_if.sv
// Command, response and shared-databus signals between a host and the matrix op sequencer.
// The host/environment side uses master, the sequencer uses slave.
interface matrix_op_sequencer_if #(
    parameter int DATA_W = 256,
    parameter int UNITS  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_unit;
    logic [DATA_W-1:0] cmd_operand;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_status;

    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_in;

    logic [UNITS-1:0]  unit_sel;
    logic              unit_rw;
    logic              unit_en;
    logic              unit_done;

    modport master (
        output cmd_valid, cmd_unit, cmd_operand, rsp_ready, bus_in, unit_done,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status,
        input  bus_out, bus_oe, unit_sel, unit_rw, unit_en
    );

    modport slave (
        input  cmd_valid, cmd_unit, cmd_operand, rsp_ready, bus_in, unit_done,
        output cmd_ready, rsp_valid, rsp_data, rsp_status,
        output bus_out, bus_oe, unit_sel, unit_rw, unit_en
    );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Sequences one command at a time through a shared-databus matrix unit: load operand, wait for done, return result.
// Optional READ watchdog: define MATSEQ_TIMEOUT_EN to return status 10 after TIMEOUT_CYCLES READ cycles.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | ready for a command; bad unit index goes straight to S_RESP
//   S_WRITE | one cycle driving the operand onto the bus, unit loads it
//   S_READ  | unit drives its result; wait for unit_done
//   S_RESP  | hold response until rsp_ready
module matrix_op_sequencer #(
    parameter int DATA_W         = 256,
    parameter int UNITS          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset_l,
    matrix_op_sequencer_if.slave   mif,
    output logic                   busy_o,
    output logic [15:0]            op_count_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_BAD = 2'b01;

    state_t            state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [1:0]        rsp_status_q;
    logic              bus_oe_q;
    logic [DATA_W-1:0] bus_out_q;
    logic [UNITS-1:0]  unit_sel_q;
    logic              unit_rw_q;
    logic              unit_en_q;
    logic              busy_q;
    logic [15:0]       op_count_q;

    logic [UNITS-1:0]  unit_sel_d;
    logic              bad_unit_d;

`ifdef MATSEQ_TIMEOUT_EN
    localparam int         TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] ST_TMO = 2'b10;
    logic [TMO_W-1:0] tmo_cnt_q;
`else
    // Without the watchdog the limit has no effect; keep the parameter referenced.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
    end
`endif

    // An index with no matching select line is a bad unit.
    always_comb begin
        unit_sel_d = '0;
        bad_unit_d = 1'b1;
        for (int i = 0; i < UNITS; i++) begin
            if (mif.cmd_unit == 2'(i)) begin
                unit_sel_d[i] = 1'b1;
                bad_unit_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            bus_oe_q     <= 1'b0;
            bus_out_q    <= '0;
            unit_sel_q   <= '0;
            unit_rw_q    <= 1'b0;
            unit_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
`ifdef MATSEQ_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mif.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (bad_unit_d) begin
                            state_q      <= S_RESP;
                            rsp_valid_q  <= 1'b1;
                            rsp_data_q   <= '0;
                            rsp_status_q <= ST_BAD;
                        end else begin
                            state_q    <= S_WRITE;
                            bus_oe_q   <= 1'b1;
                            bus_out_q  <= mif.cmd_operand;
                            unit_sel_q <= unit_sel_d;
                            unit_rw_q  <= 1'b1;
                            unit_en_q  <= 1'b1;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state_q   <= S_READ;
                    bus_oe_q  <= 1'b0;
                    bus_out_q <= '0;
                    unit_rw_q <= 1'b0;
`ifdef MATSEQ_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                S_READ: begin
                    // x/z on unit_done evaluates false here, so only a clean 1 completes.
                    if (mif.unit_done) begin
                        state_q      <= S_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= mif.bus_in;
                        rsp_status_q <= ST_OK;
                        unit_sel_q   <= '0;
                        unit_en_q    <= 1'b0;
                    end
`ifdef MATSEQ_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q      <= S_RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= '0;
                        rsp_status_q <= ST_TMO;
                        unit_sel_q   <= '0;
                        unit_en_q    <= 1'b0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (mif.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        if (rsp_status_q == ST_OK) begin
                            op_count_q <= op_count_q + 16'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mif.cmd_ready  = cmd_ready_q;
    assign mif.rsp_valid  = rsp_valid_q;
    assign mif.rsp_data   = rsp_data_q;
    assign mif.rsp_status = rsp_status_q;
    assign mif.bus_oe     = bus_oe_q;
    assign mif.bus_out    = bus_out_q;
    assign mif.unit_sel   = unit_sel_q;
    assign mif.unit_rw    = unit_rw_q;
    assign mif.unit_en    = unit_en_q;
    assign busy_o         = busy_q;
    assign op_count_o     = op_count_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Randomized bench for matrix_op_sequencer: a per-transaction timeline model sets expected outputs each cycle.
// Build with or without MATSEQ_TIMEOUT_EN; expectations follow the same macro.
`timescale 1ns/1ps
module tb_matrix_op_sequencer;
    localparam int DATA_W = 256;
    localparam int UNITS  = 2;
    localparam int TMO    = 16;

    localparam logic [DATA_W-1:0] OP_SEQ =
        256'h0010_000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001;
    localparam logic [DATA_W-1:0] T_LIT =
        256'h0010_000c_0008_0004_000f_000b_0007_0003_000e_000a_0006_0002_000d_0009_0005_0001;
    localparam logic [DATA_W-1:0] A_LIT =
        256'h0020_001e_001c_001a_0018_0016_0014_0012_0010_000e_000c_000a_0008_0006_0004_0002;

    logic        clk = 1'b0;
    logic        reset_l = 1'b1;
    logic        busy;
    logic [15:0] op_count;

    matrix_op_sequencer_if #(.DATA_W(DATA_W), .UNITS(UNITS)) mif ();

    matrix_op_sequencer #(.DATA_W(DATA_W), .UNITS(UNITS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .mif        (mif),
        .busy_o     (busy),
        .op_count_o (op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic              e_cmd_ready, e_rsp_valid, e_bus_oe, e_unit_rw, e_unit_en, e_busy, e_chk_rsp;
    logic [DATA_W-1:0] e_rsp_data, e_bus_out;
    logic [1:0]        e_rsp_status;
    logic [UNITS-1:0]  e_unit_sel;
    logic [15:0]       e_op_count;
    bit                chk_en = 1'b0;

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmd_ready", DATA_W'(mif.cmd_ready), DATA_W'(e_cmd_ready));
            check("rsp_valid", DATA_W'(mif.rsp_valid), DATA_W'(e_rsp_valid));
            check("bus_oe",    DATA_W'(mif.bus_oe),    DATA_W'(e_bus_oe));
            check("bus_out",   mif.bus_out,            e_bus_out);
            check("unit_sel",  DATA_W'(mif.unit_sel),  DATA_W'(e_unit_sel));
            check("unit_rw",   DATA_W'(mif.unit_rw),   DATA_W'(e_unit_rw));
            check("unit_en",   DATA_W'(mif.unit_en),   DATA_W'(e_unit_en));
            check("busy",      DATA_W'(busy),          DATA_W'(e_busy));
            check("op_count",  DATA_W'(op_count),      DATA_W'(e_op_count));
            if (e_chk_rsp) begin
                check("rsp_data",   mif.rsp_data,            e_rsp_data);
                check("rsp_status", DATA_W'(mif.rsp_status), DATA_W'(e_rsp_status));
            end
        end
    end

    // Latency from command handshake cycle to first rsp_valid cycle, plus the response seen then.
    int                cyc = 0, hs_cyc = 0, lat = -1;
    logic              prev_rv = 1'b0;
    logic [DATA_W-1:0] last_rsp_data;
    logic [1:0]        last_status;
    always @(negedge clk) begin
        cyc++;
        if (mif.cmd_valid === 1'b1 && mif.cmd_ready === 1'b1) hs_cyc = cyc;
        if (mif.rsp_valid === 1'b1 && prev_rv !== 1'b1) begin
            lat           = cyc - hs_cyc;
            last_rsp_data = mif.rsp_data;
            last_status   = mif.rsp_status;
        end
        prev_rv = mif.rsp_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not complete, time %0t", $time);
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [UNITS-1:0] onehot(input int u);
        logic [UNITS-1:0] s;
        s = '0;
        s[u] = 1'b1;
        return s;
    endfunction

    // Unit 0 transposes the 4x4 matrix, unit 1 adds the matrix to itself.
    function automatic logic [DATA_W-1:0] unit_result(input int u, input logic [DATA_W-1:0] m);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                if (u == 0) r[(row*4+col)*16 +: 16] = m[(col*4+row)*16 +: 16];
                else        r[(row*4+col)*16 +: 16] = 16'(m[(row*4+col)*16 +: 16] << 1);
        return r;
    endfunction

    task automatic exp_quiet();
        e_bus_oe = 1'b0; e_bus_out = '0; e_unit_sel = '0; e_unit_rw = 1'b0; e_unit_en = 1'b0;
    endtask

    task automatic exp_reset();
        exp_quiet();
        e_cmd_ready = 1'b0; e_busy = 1'b0; e_rsp_valid = 1'b0;
        e_chk_rsp = 1'b1; e_rsp_data = '0; e_rsp_status = 2'b00; e_op_count = 16'd0;
    endtask

    task automatic exp_idle();
        exp_quiet();
        e_cmd_ready = 1'b1; e_busy = 1'b0; e_rsp_valid = 1'b0; e_chk_rsp = 1'b0;
    endtask

    task automatic exp_write(input int u, input logic [DATA_W-1:0] op);
        e_cmd_ready = 1'b0; e_busy = 1'b1; e_rsp_valid = 1'b0; e_chk_rsp = 1'b0;
        e_bus_oe = 1'b1; e_bus_out = op; e_unit_sel = onehot(u); e_unit_rw = 1'b1; e_unit_en = 1'b1;
    endtask

    task automatic exp_read(input int u);
        e_cmd_ready = 1'b0; e_busy = 1'b1; e_rsp_valid = 1'b0; e_chk_rsp = 1'b0;
        e_bus_oe = 1'b0; e_bus_out = '0; e_unit_sel = onehot(u); e_unit_rw = 1'b0; e_unit_en = 1'b1;
    endtask

    task automatic exp_resp(input logic [DATA_W-1:0] d, input logic [1:0] s);
        exp_quiet();
        e_cmd_ready = 1'b0; e_busy = 1'b1; e_rsp_valid = 1'b1;
        e_chk_rsp = 1'b1; e_rsp_data = d; e_rsp_status = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with cmd_ready expected high; returns in the following IDLE cycle.
    task automatic do_op(input int u, input logic [DATA_W-1:0] op, input int n_read,
                         input int bp, input bit spur);
        logic [DATA_W-1:0] res;
        logic [1:0]        st;
        mif.cmd_valid   = 1'b1;
        mif.cmd_unit    = 2'(u);
        mif.cmd_operand = op;
        mif.unit_done   = spur;
        tick();
        mif.cmd_valid   = 1'b0;
        mif.cmd_unit    = 2'($urandom);
        mif.cmd_operand = rand_word();
        if (u < UNITS) begin
            exp_write(u, op);
            mif.unit_done = spur;
            mif.bus_in    = rand_word();
            tick();
            res = unit_result(u, op);
            st  = 2'b00;
            for (int k = 1; k <= n_read; k++) begin
`ifdef MATSEQ_TIMEOUT_EN
                if (k > TMO) begin
                    res = '0;
                    st  = 2'b10;
                    break;
                end
`endif
                exp_read(u);
                if (k == n_read) begin
                    mif.unit_done = 1'b1;
                    mif.bus_in    = res;
                end else begin
                    mif.unit_done = ($urandom_range(0, 1) == 0) ? 1'bz : 1'b0;
                    mif.bus_in    = rand_word();
                end
                tick();
            end
        end else begin
            res = '0;
            st  = 2'b01;
        end
        for (int k = 0; k <= bp; k++) begin
            exp_resp(res, st);
            mif.rsp_ready = (k == bp);
            mif.unit_done = 1'($urandom_range(0, 1));
            mif.bus_in    = rand_word();
            tick();
        end
        mif.rsp_ready = 1'b0;
        mif.unit_done = 1'b0;
        if (st == 2'b00) e_op_count = e_op_count + 16'd1;
        exp_idle();
    endtask

    initial begin
        int u, n_read, bp, gap;
        mif.cmd_valid = 1'b0; mif.cmd_unit = 2'd0; mif.cmd_operand = '0;
        mif.rsp_ready = 1'b0; mif.bus_in = '0; mif.unit_done = 1'b0;

        #2;
        reset_l = 1'b0;
        exp_reset();
        chk_en = 1'b1;
        #1;
        check("reset_cmd_ready", DATA_W'(mif.cmd_ready), '0);
        check("reset_op_count",  DATA_W'(op_count), '0);
        tick(); tick(); tick();
        reset_l = 1'b1;
        tick();
        exp_idle();
        check("cmd_ready_after_release", DATA_W'(mif.cmd_ready), DATA_W'(1));

        check("pin_transpose", unit_result(0, OP_SEQ), T_LIT);
        check("pin_add",       unit_result(1, OP_SEQ), A_LIT);

        do_op(0, OP_SEQ, 1, 0, 1'b0);
        check("transpose_latency", DATA_W'(lat), DATA_W'(3));
        check("transpose_data",    last_rsp_data, T_LIT);
        check("transpose_status",  DATA_W'(last_status), DATA_W'(0));
        check("transpose_op_count", DATA_W'(op_count), DATA_W'(1));

        do_op(3, rand_word(), 1, 0, 1'b0);
        check("bad_unit_latency",  DATA_W'(lat), DATA_W'(1));
        check("bad_unit_status",   DATA_W'(last_status), DATA_W'(1));
        check("bad_unit_op_count", DATA_W'(op_count), DATA_W'(1));

        do_op(1, OP_SEQ, 2, 5, 1'b0);
        check("backpressure_data", last_rsp_data, A_LIT);
        check("backpressure_op_count", DATA_W'(op_count), DATA_W'(2));

        do_op(0, rand_word(), 3, 0, 1'b1);
        check("spurious_latency", DATA_W'(lat), DATA_W'(5));

        // Mid-op reset during READ.
        mif.cmd_valid = 1'b1; mif.cmd_unit = 2'd1; mif.cmd_operand = OP_SEQ;
        tick();
        mif.cmd_valid = 1'b0;
        exp_write(1, OP_SEQ);
        tick();
        exp_read(1);
        tick();
        #1;
        reset_l = 1'b0;
        #1;
        check("midrst_bus_oe",   DATA_W'(mif.bus_oe),   '0);
        check("midrst_unit_sel", DATA_W'(mif.unit_sel), '0);
        check("midrst_unit_en",  DATA_W'(mif.unit_en),  '0);
        check("midrst_busy",     DATA_W'(busy),         '0);
        exp_reset();
        tick(); tick();
        reset_l = 1'b1;
        tick();
        exp_idle();
        check("midrst_cmd_ready", DATA_W'(mif.cmd_ready), DATA_W'(1));
        tick(); tick();

        // unit_done never arrives for 100 READ cycles.
        do_op(0, rand_word(), 101, 0, 1'b0);
`ifdef MATSEQ_TIMEOUT_EN
        check("timeout_latency", DATA_W'(lat), DATA_W'(TMO + 2));
        check("timeout_status",  DATA_W'(last_status), DATA_W'(2));
        check("timeout_data",    last_rsp_data, '0);
`else
        check("no_timeout_latency", DATA_W'(lat), DATA_W'(103));
        check("no_timeout_status",  DATA_W'(last_status), DATA_W'(0));
`endif

        for (int t = 0; t < 80; t++) begin
            u      = $urandom_range(0, 3);
            n_read = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 6);
            bp     = $urandom_range(0, 3);
            do_op(u, rand_word(), n_read, bp, 1'($urandom_range(0, 1)));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                mif.unit_done = 1'($urandom_range(0, 1));
                tick();
            end
            mif.unit_done = 1'b0;
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
